fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF pipe stage of the 5-stage MIPS core: PC register, PC+4 adder, next-PC select, IF/ID pipeline register.
//   Drives instruction-memory address; its IF/ID outputs feed control_main, Hazard_Unit and register read in ID.
//   Honours Hazard_Unit stall (PC_Write/IFID_Write), ID-stage jump redirect, EX/MEM branch redirect with flush.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   IMEM_AW    10             instruction-memory word-address width (1024 words)
// PORTS
//   clock          in   1        single core clock, all state on posedge
//   reset          in   1        asynchronous, active-low; clears all state immediately
//   PC_Write       in   1        from Hazard_Unit; 0 = hold PC
//   IFID_Write     in   1        from Hazard_Unit; 0 = hold IF/ID register
//   Jump           in   1        from control_main (decodes IFID_instr), ID-stage jump
//   PCSrc          in   1        EX/MEM taken branch (EqBranch&Zero | NeqBranch&~Zero)
//   Branch_target  in   32       EX/MEM branch target byte address
//   imem_addr      out  IMEM_AW  word address = PC[IMEM_AW+1:2]
//   imem_rdata     in   32       combinational instruction read for imem_addr
//   PC             out  32       current fetch PC
//   IFID_instr     out  32       registered instruction
//   IFID_PCplus4   out  32       registered PC+4 of that instruction
//   IFID_valid     out  1        1 = IF/ID holds a real fetched instruction, 0 = bubble
//   perf_fetch     out  32       fetched-instruction count (FETCH_PERF_EN)
//   perf_stall     out  32       stall-cycle count (FETCH_PERF_EN)
//   perf_flush     out  32       flush-event count (FETCH_PERF_EN)
// BEHAVIOUR
//   Reset (reset=0, async): PC=RESET_PC, IFID_instr=32'h0 (NOP), IFID_PCplus4=0, IFID_valid=0, perf_*=0.
//   First fetch occurs the cycle after reset deasserts; IF/ID valid 1 cycle after fetch.
//   PCplus4 = PC + 4, mod 2^32 (wraps 32'hFFFF_FFFC -> 0, no flag). PC[1:0] always 00.
//   Jump target = {IFID_PCplus4[31:28], IFID_instr[25:0], 2'b00}.
//   Next-state priority each posedge (highest first):
//     1 PCSrc=1         : PC<=Branch_target; IF/ID<=NOP, valid=0. Overrides stall and Jump.
//     2 Jump=1 & IFID_Write=1 : PC<=jump target; IF/ID<=NOP, valid=0 (1-cycle bubble).
//                          Jump while IFID_Write=0 ignored (held jump re-asserts after stall).
//     3 stall           : PC_Write=0 holds PC; IFID_Write=0 holds IFID_instr/PCplus4/valid.
//     4 normal          : PC<=PCplus4; IFID_instr<=imem_rdata, IFID_PCplus4<=PCplus4, valid=1.
//   PC_Write and IFID_Write are independent; each gates only its own register.
//   Flush forces IFID_instr to 32'h0 (sll $0,$0,0) so downstream decode sees a true NOP.
//   Reset mid-operation: all state returns to reset values asynchronously, no partial update.
// CONFIGURATION
//   FETCH_PERF_EN defined: perf_fetch +1 per case-4 cycle; perf_stall +1 per cycle PC_Write=0 w/o PCSrc;
//     perf_flush +1 per case-1 or case-2 cycle. All saturate at 32'hFFFF_FFFF, clear on reset.
//   FETCH_PERF_EN undefined: perf_* tied to 32'h0, no counter flops synthesised; ports remain.
// STRUCTURE
//   constants.h: add `NOP_INSTR (32'h0) and `RESET_PC default; opcodes stay there.
//   One sub-module: fetch_perf_counters (three saturating counters), instantiated only under FETCH_PERF_EN.
//   PC register, adder and next-PC mux stay inline in fetch_stage.
// TESTING
//   Reset then 4 cycles, imem word n = 32'h2000_0000+n -> PC 0,4,8,C,10; IFID_instr follows one cycle later, valid=1.
//   PC_Write=0, IFID_Write=0 at PC=8 for 2 cycles -> PC stays 8, IFID_instr stays word 1, perf_stall=2.
//   IFID_instr=J 0x0000040 (PCplus4=0x10), Jump=1 -> next PC=0x100, IFID_instr=0, valid=0, perf_flush+1.
//   PCSrc=1, Branch_target=0x40 same cycle as Jump=1 and PC_Write=0 -> PC=0x40, IF/ID flushed, jump lost.
//   PC forced near top: PC=32'hFFFF_FFFC, normal step -> PC=0, IFID_PCplus4=0.
//   reset pulsed low mid-cycle while stalled -> PC=RESET_PC, IFID_valid=0, perf_* =0 without clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants, next-state select encoding and helpers for the IF stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_STEP   = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_BRANCH = 2'd2
    } fetch_sel_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Three saturating event counters for the fetch stage (fetches, stalls, flushes).
module fetch_perf_counters
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_evt,
    input  logic        stall_evt,
    input  logic        flush_evt,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fetch_evt) fetch_cnt <= sat_inc(fetch_cnt);
            if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
            if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, PC+4, next-PC select and IF/ID register.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PC_Write,
    input  logic               IFID_Write,
    input  logic               Jump,
    input  logic               PCSrc,
    input  logic [31:0]        Branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        PC,
    output logic [31:0]        IFID_instr,
    output logic [31:0]        IFID_PCplus4,
    output logic               IFID_valid,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
);

    fetch_sel_e  sel;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;

    assign pc_plus4    = PC + 32'd4;
    assign jump_target = {IFID_PCplus4[31:28], IFID_instr[25:0], 2'b00};
    assign imem_addr   = PC[IMEM_AW+1:2];

    // A jump only redirects when the instruction carrying it advances out of IF/ID;
    // a held jump re-asserts once the stall lifts.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        sel = SEL_STEP;
        if (PCSrc)
            sel = SEL_BRANCH;
        else if (Jump && IFID_Write)
            sel = SEL_JUMP;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            PC           <= word_align(RESET_PC);
            IFID_instr   <= NOP_INSTR;
            IFID_PCplus4 <= '0;
            IFID_valid   <= 1'b0;
        end else begin
            unique case (sel)
                SEL_BRANCH, SEL_JUMP: begin
                    PC           <= (sel == SEL_BRANCH) ? word_align(Branch_target) : jump_target;
                    IFID_instr   <= NOP_INSTR;
                    IFID_PCplus4 <= '0;
                    IFID_valid   <= 1'b0;
                end
                default: begin
                    if (PC_Write)
                        PC <= pc_plus4;
                    if (IFID_Write) begin
                        IFID_instr   <= imem_rdata;
                        IFID_PCplus4 <= pc_plus4;
                        IFID_valid   <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_evt;
    logic stall_evt;
    logic flush_evt;

    assign fetch_evt = (sel == SEL_STEP) && PC_Write && IFID_Write;
    assign stall_evt = !PCSrc && !PC_Write;
    assign flush_evt = (sel != SEL_STEP);

    fetch_perf_counters u_perf (
        .clk       (clock),
        .rst_n     (reset),
        .fetch_evt (fetch_evt),
        .stall_evt (stall_evt),
        .flush_evt (flush_evt),
        .fetch_cnt (perf_fetch),
        .stall_cnt (perf_stall),
        .flush_cnt (perf_flush)
    );
`else
    assign perf_fetch = '0;
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
